// File: rtl/zeptobars_pkg.sv
// Shared definitions for the oscillator test chip configuration-chain loader.
// Holds the FSM state encoding, the chain length and the default shift-clock divider.
// No ports; imported by shift_cfg_loader_zeptobars.
package zeptobars_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOW  = 2'd1;
  localparam logic [1:0] HIGH = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = IDLE,
    ST_LOW  = LOW,
    ST_HIGH = HIGH,
    ST_DONE = DONE
  } state_t;

  localparam int CHAIN_W      = 12;
  localparam int DIV_DEFAULT  = 4;
  localparam int SYNC_DEFAULT = 2;

endpackage

// File: rtl/sync_ff_zeptobars.sv
// Multi-flop synchronizer for a single asynchronous bit, cleared to 0 on reset.
// Ports: clk, rst (async active-high), d (async input), q (synchronized output).
// Latency: STAGES clk cycles from d to q.
module sync_ff_zeptobars #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr <= '0;
    end else begin
      sr <= {sr[STAGES-2:0], d};
    end
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/shift_cfg_loader_zeptobars.sv
// Host-side master for the test chip serial config chain: serializes cfg_data MSB-first
// on shift_clk/shift_dta (2*DIV clk per bit) while capturing old chain contents from shift_out.
// Ports: cfg_data/cfg_valid/cfg_ready handshake in, busy/done/rd_data status out, shift_* chain pins.
module shift_cfg_loader_zeptobars
  import zeptobars_pkg::*;
#(
  parameter int WIDTH       = CHAIN_W,
  parameter int DIV         = DIV_DEFAULT,
  parameter int SYNC_STAGES = SYNC_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] cfg_data,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  output logic             busy,
  output logic             shift_clk,
  output logic             shift_dta,
  input  logic             shift_out,
  output logic [WIDTH-1:0] rd_data,
  output logic             done
);

  localparam int DW = $clog2(DIV);
  localparam int BW = $clog2(WIDTH);

  state_t           state;
  logic [DW-1:0]    divcnt;
  logic [BW-1:0]    bitcnt;
  // Only the bits still to be sent after the MSB; the MSB goes straight to shift_dta on accept.
  logic [WIDTH-2:0] tx_sr;
  logic [WIDTH-1:0] rx_sr;
  logic             sync_out;

  sync_ff_zeptobars #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (shift_out),
    .q  (sync_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      divcnt    <= '0;
      bitcnt    <= '0;
      tx_sr     <= '0;
      rx_sr     <= '0;
      shift_clk <= 1'b0;
      shift_dta <= 1'b0;
      rd_data   <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
      cfg_ready <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cfg_valid) begin
            tx_sr     <= cfg_data[WIDTH-2:0];
            shift_dta <= cfg_data[WIDTH-1];
            bitcnt    <= BW'(WIDTH - 1);
            divcnt    <= DW'(DIV - 1);
            cfg_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= ST_LOW;
          end
        end

        ST_LOW: begin
          if (divcnt == '0) begin
            // Sample before raising shift_clk: the first sample is the old chain MSB.
            rx_sr     <= {rx_sr[WIDTH-2:0], sync_out};
            shift_clk <= 1'b1;
            divcnt    <= DW'(DIV - 1);
            state     <= ST_HIGH;
          end else begin
            divcnt <= divcnt - 1'b1;
          end
        end

        ST_HIGH: begin
          if (divcnt == '0) begin
            shift_clk <= 1'b0;
            if (bitcnt == '0) begin
              // Register readback and done together on entry so both are visible during DONE.
              rd_data   <= rx_sr;
              done      <= 1'b1;
              shift_dta <= 1'b0;
              state     <= ST_DONE;
            end else begin
              // shift_dta only moves on the falling shift_clk edge.
              bitcnt    <= bitcnt - 1'b1;
              shift_dta <= tx_sr[WIDTH-2];
              tx_sr     <= {tx_sr[WIDTH-3:0], 1'b0};
              divcnt    <= DW'(DIV - 1);
              state     <= ST_LOW;
            end
          end else begin
            divcnt <= divcnt - 1'b1;
          end
        end

        ST_DONE: begin
          cfg_ready <= 1'b1;
          busy      <= 1'b0;
          state     <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_cfg_loader_zeptobars.sv
// Directed bench for shift_cfg_loader_zeptobars: one DIV=4 and one DIV=2 instance,
// each driving a behavioural 12-bit chain model (shift_out = chain[11]).
// Checks timing, readback, ignored requests while busy and reset abort.
module tb_shift_cfg_loader_zeptobars;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [11:0] cfg_data_a, cfg_data_b;
  logic        cfg_valid_a, cfg_valid_b;
  logic        cfg_ready_a, cfg_ready_b;
  logic        busy_a, busy_b;
  logic        sclk_a, sclk_b;
  logic        sdta_a, sdta_b;
  logic [11:0] rd_a, rd_b;
  logic        done_a, done_b;

  logic [11:0] chain_a = 12'h000;
  logic [11:0] chain_b = 12'h000;

  always @(posedge sclk_a) chain_a <= {chain_a[10:0], sdta_a};
  always @(posedge sclk_b) chain_b <= {chain_b[10:0], sdta_b};

  shift_cfg_loader_zeptobars #(.WIDTH(12), .DIV(4), .SYNC_STAGES(2)) dut_a (
    .clk(clk), .rst(rst), .cfg_data(cfg_data_a), .cfg_valid(cfg_valid_a),
    .cfg_ready(cfg_ready_a), .busy(busy_a), .shift_clk(sclk_a), .shift_dta(sdta_a),
    .shift_out(chain_a[11]), .rd_data(rd_a), .done(done_a)
  );

  shift_cfg_loader_zeptobars #(.WIDTH(12), .DIV(2), .SYNC_STAGES(2)) dut_b (
    .clk(clk), .rst(rst), .cfg_data(cfg_data_b), .cfg_valid(cfg_valid_b),
    .cfg_ready(cfg_ready_b), .busy(busy_b), .shift_clk(sclk_b), .shift_dta(sdta_b),
    .shift_out(chain_b[11]), .rd_data(rd_b), .done(done_b)
  );

  int checks = 0;
  int failures = 0;

  // Selects which instance the shared transfer task drives and observes.
  logic sel = 1'b0;
  wire        m_ready = sel ? cfg_ready_b : cfg_ready_a;
  wire        m_busy  = sel ? busy_b : busy_a;
  wire        m_sclk  = sel ? sclk_b : sclk_a;
  wire        m_sdta  = sel ? sdta_b : sdta_a;
  wire        m_done  = sel ? done_b : done_a;
  wire [11:0] m_rd    = sel ? rd_b : rd_a;
  wire [11:0] m_chain = sel ? chain_b : chain_a;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [11:0] d);
    if (sel) begin
      cfg_valid_b = v;
      cfg_data_b  = d;
    end else begin
      cfg_valid_a = v;
      cfg_data_a  = d;
    end
  endtask

  // One complete transfer with per-cycle timing checks. With churn set, cfg_valid stays
  // high and cfg_data keeps changing during the transfer.
  task automatic xfer(input logic s, input logic [11:0] word, input int div, input logic churn,
                      input logic [11:0] exp_rd, input string tag);
    int   k, nrise, last_rise, since_chg, since_rise, done_k;
    logic got, prev_clk, prev_dta;
    sel = s;
    got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (m_ready) got = 1'b1;
    end
    chk({tag, " ready_before_accept"}, 32'(got), 32'd1);
    drive(1'b1, word);
    @(posedge clk); #1;
    if (!churn) drive(1'b0, ~word);
    chk({tag, " busy_after_accept"}, 32'(m_busy), 32'd1);
    chk({tag, " ready_low_after_accept"}, 32'(m_ready), 32'd0);
    nrise = 0; last_rise = 0; since_chg = 0; since_rise = 1000; done_k = -1;
    prev_clk = m_sclk; prev_dta = m_sdta;
    for (k = 1; k <= 2 * div * 12 + 20 && done_k < 0; k++) begin
      if (churn) drive(1'b1, word ^ 12'(k * 37 + 1));
      @(posedge clk); #1;
      since_rise++;
      if (m_sdta !== prev_dta) begin
        if (nrise > 0) chk({tag, " dta_hold"}, 32'(since_rise >= div), 32'd1);
        since_chg = 0;
      end else begin
        since_chg++;
      end
      if (m_sclk && !prev_clk) begin
        nrise++;
        chk({tag, " dta_setup"}, 32'(since_chg >= div), 32'd1);
        if (nrise == 1) chk({tag, " first_rise_cycle"}, 32'(k), 32'(div));
        else chk({tag, " bit_period"}, 32'(k - last_rise), 32'(2 * div));
        last_rise = k;
        since_rise = 0;
      end
      if (m_done) begin
        done_k = k;
        chk({tag, " busy_at_done"}, 32'(m_busy), 32'd1);
        drive(1'b0, 12'h000);
      end else if (churn) begin
        chk({tag, " ready_low_while_busy"}, 32'(m_ready), 32'd0);
      end
      prev_clk = m_sclk;
      prev_dta = m_sdta;
    end
    chk({tag, " done_cycle"}, 32'(done_k), 32'(2 * div * 12));
    chk({tag, " rise_count"}, 32'(nrise), 32'd12);
    chk({tag, " rd_data"}, 32'(m_rd), 32'(exp_rd));
    chk({tag, " chain"}, 32'(m_chain), 32'(word));
    @(posedge clk); #1;
    chk({tag, " ready_after_done"}, 32'(m_ready), 32'd1);
    chk({tag, " done_one_cycle"}, 32'(m_done), 32'd0);
    chk({tag, " busy_after_done"}, 32'(m_busy), 32'd0);
    chk({tag, " rd_hold"}, 32'(m_rd), 32'(exp_rd));
  endtask

  int   nr;
  logic pc, got_r, saw_done, saw_rise;

  initial begin
    rst = 1'b1;
    cfg_valid_a = 1'b0; cfg_data_a = 12'h000;
    cfg_valid_b = 1'b0; cfg_data_b = 12'h000;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    chk("idle shift_clk", 32'(sclk_a), 32'd0);
    chk("idle shift_dta", 32'(sdta_a), 32'd0);
    chk("idle cfg_ready", 32'(cfg_ready_a), 32'd1);
    chk("idle busy", 32'(busy_a), 32'd0);
    chk("idle rd_data", 32'(rd_a), 32'd0);
    chk("idle done", 32'(done_a), 32'd0);
    chk("idle div2 cfg_ready", 32'(cfg_ready_b), 32'd1);
    chk("idle div2 shift_clk", 32'(sclk_b), 32'd0);

    xfer(1'b0, 12'hA5C, 4, 1'b0, 12'h000, "t1_a5c");
    xfer(1'b0, 12'h3F0, 4, 1'b0, 12'hA5C, "t2_b2b");
    xfer(1'b0, 12'h6B1, 4, 1'b1, 12'h3F0, "t3_churn");

    // Abort after the 5th rising shift_clk edge of a 0x5A3 load.
    sel = 1'b0;
    got_r = 1'b0;
    for (int i = 0; i < 300 && !got_r; i++) begin
      @(negedge clk);
      if (cfg_ready_a) got_r = 1'b1;
    end
    chk("rst_abort ready", 32'(got_r), 32'd1);
    drive(1'b1, 12'h5A3);
    @(posedge clk); #1;
    drive(1'b0, 12'h000);
    nr = 0;
    pc = sclk_a;
    for (int i = 0; i < 200 && nr < 5; i++) begin
      @(posedge clk); #1;
      if (sclk_a && !pc) nr++;
      pc = sclk_a;
    end
    chk("rst_abort five_rises", 32'(nr), 32'd5);
    chk("rst_abort clk_high_before", 32'(sclk_a), 32'd1);
    chk("rst_abort dta_before", 32'(sdta_a), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_abort shift_clk_async", 32'(sclk_a), 32'd0);
    chk("rst_abort shift_dta_async", 32'(sdta_a), 32'd0);
    chk("rst_abort cfg_ready", 32'(cfg_ready_a), 32'd1);
    chk("rst_abort busy", 32'(busy_a), 32'd0);
    chk("rst_abort done", 32'(done_a), 32'd0);
    chk("rst_abort chain_partial", 32'(chain_a), 32'h62B);
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    saw_rise = 1'b0;
    repeat (120) begin
      @(negedge clk);
      if (done_a) saw_done = 1'b1;
      if (sclk_a) saw_rise = 1'b1;
    end
    chk("rst_abort no_done", 32'(saw_done), 32'd0);
    chk("rst_abort no_shift_clk", 32'(saw_rise), 32'd0);

    xfer(1'b0, 12'hFFF, 4, 1'b0, 12'h62B, "t4_after_rst");
    xfer(1'b1, 12'h001, 2, 1'b0, 12'h000, "t5_div2");
    xfer(1'b1, 12'h800, 2, 1'b0, 12'h001, "t6_div2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
